// File: rtl/csr_if.sv
// CSR access bus between the execute stage (master) and the M-mode CSR file (slave).
// Carries the address, read-modify-write opcode, operand, read data and illegal flag.
interface csr_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     idx;
  logic [1:0]      op;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            illegal;

  modport master (
    output idx,
    output op,
    output wdata,
    input  rdata,
    input  illegal
  );

  modport slave (
    input  idx,
    input  op,
    input  wdata,
    output rdata,
    output illegal
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mie/mip/mtvec/mscratch/mepc/mcause, trap entry, mret, timer irq.
// Define CSR_COUNTERS_EN to build the mcycle/minstret performance counters.
module csr_file #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_if.slave            csr,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_valid_i,
  input  logic            instret_i,
  input  logic            irq_timer_i,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_out_o,
  output logic            irq_pending_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
`endif

  localparam logic [XLEN-1:0] WORD_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  logic            mstatusMie_q, mstatusMie_d;
  logic            mstatusMpie_q, mstatusMpie_d;
  logic            mieMtie_q, mieMtie_d;
  logic [XLEN-1:2] mtvecBase_q, mtvecBase_d;
  logic            mtvecMode_q, mtvecMode_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
`else
  logic            unusedInstret;
  assign unusedInstret = instret_i;
`endif

  logic [XLEN-1:0] mstatusRead;
  logic [XLEN-1:0] mieRead;
  logic [XLEN-1:0] mipRead;
  logic [XLEN-1:0] mtvecRead;
  logic [XLEN-1:0] readValue;
  logic [XLEN-1:0] writeValue;
  logic            implemented;
  logic            csrActive;
  logic            csrWrite;
  csr_op_e         opCode;

  // Architectural views of the sparse registers; MPP is hardwired to M-mode.
  always_comb begin
    mstatusRead        = '0;
    mstatusRead[12:11] = 2'b11;
    mstatusRead[7]     = mstatusMpie_q;
    mstatusRead[3]     = mstatusMie_q;
    mieRead            = '0;
    mieRead[7]         = mieMtie_q;
    mipRead            = '0;
    mipRead[7]         = irq_timer_i;
    mtvecRead          = {mtvecBase_q, 1'b0, mtvecMode_q};
  end

  // Address decode: unimplemented indices read as zero and are flagged only on an active op.
  always_comb begin
    readValue   = '0;
    implemented = 1'b1;
    case (csr.idx)
      ADDR_MSTATUS:  readValue = mstatusRead;
      ADDR_MIE:      readValue = mieRead;
      ADDR_MIP:      readValue = mipRead;
      ADDR_MTVEC:    readValue = mtvecRead;
      ADDR_MSCRATCH: readValue = mscratch_q;
      ADDR_MEPC:     readValue = mepc_q;
      ADDR_MCAUSE:   readValue = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   readValue = mcycle_q;
      ADDR_MINSTRET: readValue = minstret_q;
`endif
      default:       implemented = 1'b0;
    endcase
  end

  assign opCode      = csr_op_e'(csr.op);
  assign csrActive   = (opCode != OP_NONE);
  assign csrWrite    = csrActive && implemented;
  assign csr.rdata   = readValue;
  assign csr.illegal = csrActive && !implemented;

  always_comb begin
    writeValue = readValue;
    case (opCode)
      OP_WRITE: writeValue = csr.wdata;
      OP_SET:   writeValue = readValue | csr.wdata;
      OP_CLEAR: writeValue = readValue & ~csr.wdata;
      default:  writeValue = readValue;
    endcase
  end

  // Trap beats mret beats a software write, but only for the registers the winner touches.
  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mieMtie_d     = mieMtie_q;
    mtvecBase_d   = mtvecBase_q;
    mtvecMode_d   = mtvecMode_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;

    if (trap_valid_i) begin
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
    end else if (mret_valid_i) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
    end else if (csrWrite && csr.idx == ADDR_MSTATUS) begin
      mstatusMie_d  = writeValue[3];
      mstatusMpie_d = writeValue[7];
    end

    if (trap_valid_i) begin
      mepc_d   = trap_pc_i & WORD_MASK;
      mcause_d = trap_cause_i;
    end else begin
      if (csrWrite && csr.idx == ADDR_MEPC) begin
        mepc_d = writeValue & WORD_MASK;
      end
      if (csrWrite && csr.idx == ADDR_MCAUSE) begin
        mcause_d = writeValue;
      end
    end

    if (csrWrite && csr.idx == ADDR_MIE) begin
      mieMtie_d = writeValue[7];
    end
    if (csrWrite && csr.idx == ADDR_MTVEC) begin
      mtvecBase_d = writeValue[XLEN-1:2];
      mtvecMode_d = writeValue[0];
    end
    if (csrWrite && csr.idx == ADDR_MSCRATCH) begin
      mscratch_d = writeValue;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mieMtie_q     <= 1'b0;
      mtvecBase_q   <= MTVEC_RST[XLEN-1:2];
      mtvecMode_q   <= MTVEC_RST[0];
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mieMtie_q     <= mieMtie_d;
      mtvecBase_q   <= mtvecBase_d;
      mtvecMode_q   <= mtvecMode_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // Counters are never touched by trap/mret, so a software write only competes with the increment.
  always_comb begin
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = instret_i ? minstret_q + XLEN'(1) : minstret_q;
    if (csrWrite && csr.idx == ADDR_MCYCLE) begin
      mcycle_d = writeValue;
    end
    if (csrWrite && csr.idx == ADDR_MINSTRET) begin
      minstret_d = writeValue;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  logic [XLEN-1:0] vectorBase;
  logic [XLEN-1:0] causeCode;
  logic [XLEN-1:0] vectorOffset;

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  always_comb begin
    vectorBase   = {mtvecBase_q, 2'b00};
    causeCode    = {1'b0, trap_cause_i[XLEN-2:0]};
    vectorOffset = causeCode << 2;
    if (mtvecMode_q && trap_cause_i[XLEN-1]) begin
      trap_target_o = vectorBase + vectorOffset;
    end else begin
      trap_target_o = vectorBase;
    end
  end

  assign mepc_out_o    = mepc_q;
  assign irq_pending_o = mstatusMie_q && mieMtie_q && irq_timer_i;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: WARL mtvec, trap/mret, vectoring, priority, irq, illegal.
// Counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_file;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            trapValid;
  logic [XLEN-1:0] trapCause;
  logic [XLEN-1:0] trapPc;
  logic            mretValid;
  logic            instret;
  logic            irqTimer;
  logic [XLEN-1:0] trapTarget;
  logic [XLEN-1:0] mepcOut;
  logic            irqPending;

  int checks;
  int failures;

  csr_if #(.XLEN(XLEN)) csrBus ();

  csr_file #(.XLEN(XLEN), .MTVEC_RST('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr           (csrBus.slave),
    .trap_valid_i  (trapValid),
    .trap_cause_i  (trapCause),
    .trap_pc_i     (trapPc),
    .mret_valid_i  (mretValid),
    .instret_i     (instret),
    .irq_timer_i   (irqTimer),
    .trap_target_o (trapTarget),
    .mepc_out_o    (mepcOut),
    .irq_pending_o (irqPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change #1 after the rising edge so the DUT samples stable values.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    csrBus.idx   = 12'h000;
    csrBus.op    = 2'b00;
    csrBus.wdata = '0;
    trapValid    = 1'b0;
    mretValid    = 1'b0;
    instret      = 1'b0;
  endtask

  // One CSR access cycle, then the bus returns to idle.
  task automatic applyStimulus(input logic [11:0] idx, input logic [1:0] op, input logic [XLEN-1:0] data);
    csrBus.idx   = idx;
    csrBus.op    = op;
    csrBus.wdata = data;
    tick();
    csrBus.op    = 2'b00;
    csrBus.wdata = '0;
  endtask

  task automatic readCsr(input logic [11:0] idx, output logic [XLEN-1:0] value);
    csrBus.idx = idx;
    csrBus.op  = 2'b00;
    #1;
    value = csrBus.rdata;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] v;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1800) begin failures++; $display("[TB] FAIL reset_mstatus got=%h exp=%h", v, 64'h1800); end
    readCsr(12'h305, v);
    checks++;
    if (v !== 64'h0) begin failures++; $display("[TB] FAIL reset_mtvec got=%h exp=%h", v, 64'h0); end
    readCsr(12'h340, v);
    checks++;
    if (v !== 64'h0) begin failures++; $display("[TB] FAIL reset_mscratch got=%h exp=%h", v, 64'h0); end
    checks++;
    if (mepcOut !== 64'h0) begin failures++; $display("[TB] FAIL reset_mepc_out got=%h exp=%h", mepcOut, 64'h0); end
    checks++;
    if (trapTarget !== 64'h0) begin failures++; $display("[TB] FAIL reset_trap_target got=%h exp=%h", trapTarget, 64'h0); end
    checks++;
    if (irqPending !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq_pending got=%b exp=0", irqPending); end
  endtask

  task automatic test_mtvec_warl();
    logic [XLEN-1:0] v;
    applyStimulus(12'h305, 2'b01, 64'h8000_0101);
    readCsr(12'h305, v);
    checks++;
    if (v !== 64'h8000_0101) begin failures++; $display("[TB] FAIL mtvec_write got=%h exp=%h", v, 64'h8000_0101); end
    csrBus.idx   = 12'h305;
    csrBus.op    = 2'b01;
    csrBus.wdata = 64'h8000_0103;
    #1;
    checks++;
    if (csrBus.rdata !== 64'h8000_0101) begin failures++; $display("[TB] FAIL mtvec_same_cycle_old got=%h exp=%h", csrBus.rdata, 64'h8000_0101); end
    tick();
    readCsr(12'h305, v);
    checks++;
    if (v !== 64'h8000_0101) begin failures++; $display("[TB] FAIL mtvec_mode3 got=%h exp=%h", v, 64'h8000_0101); end
    applyStimulus(12'h305, 2'b11, 64'h1);
    readCsr(12'h305, v);
    checks++;
    if (v !== 64'h8000_0100) begin failures++; $display("[TB] FAIL mtvec_clear got=%h exp=%h", v, 64'h8000_0100); end
    applyStimulus(12'h305, 2'b10, 64'h0000_0F00);
    readCsr(12'h305, v);
    checks++;
    if (v !== 64'h8000_0F00) begin failures++; $display("[TB] FAIL mtvec_set got=%h exp=%h", v, 64'h8000_0F00); end
  endtask

  task automatic test_trap_mret();
    logic [XLEN-1:0] v;
    applyStimulus(12'h300, 2'b01, 64'h8);
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1808) begin failures++; $display("[TB] FAIL mstatus_mie_set got=%h exp=%h", v, 64'h1808); end
    trapValid = 1'b1;
    trapPc    = 64'h8000_0010;
    trapCause = 64'd11;
    tick();
    trapValid = 1'b0;
    readCsr(12'h341, v);
    checks++;
    if (v !== 64'h8000_0010) begin failures++; $display("[TB] FAIL trap_mepc got=%h exp=%h", v, 64'h8000_0010); end
    readCsr(12'h342, v);
    checks++;
    if (v !== 64'd11) begin failures++; $display("[TB] FAIL trap_mcause got=%h exp=%h", v, 64'd11); end
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1880) begin failures++; $display("[TB] FAIL trap_mstatus got=%h exp=%h", v, 64'h1880); end
    checks++;
    if (mepcOut !== 64'h8000_0010) begin failures++; $display("[TB] FAIL trap_mepc_out got=%h exp=%h", mepcOut, 64'h8000_0010); end
    mretValid = 1'b1;
    tick();
    mretValid = 1'b0;
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1888) begin failures++; $display("[TB] FAIL mret_mstatus got=%h exp=%h", v, 64'h1888); end
  endtask

  task automatic test_vectored();
    applyStimulus(12'h305, 2'b01, 64'h101);
    trapCause = 64'h8000_0000_0000_0007;
    #1;
    checks++;
    if (trapTarget !== 64'h11C) begin failures++; $display("[TB] FAIL vec_irq_target got=%h exp=%h", trapTarget, 64'h11C); end
    trapCause = 64'd2;
    #1;
    checks++;
    if (trapTarget !== 64'h100) begin failures++; $display("[TB] FAIL vec_exc_target got=%h exp=%h", trapTarget, 64'h100); end
    applyStimulus(12'h305, 2'b01, 64'h100);
    trapCause = 64'h8000_0000_0000_0007;
    #1;
    checks++;
    if (trapTarget !== 64'h100) begin failures++; $display("[TB] FAIL direct_irq_target got=%h exp=%h", trapTarget, 64'h100); end
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] v;
    trapValid    = 1'b1;
    trapPc       = 64'h2003;
    trapCause    = 64'd5;
    csrBus.idx   = 12'h341;
    csrBus.op    = 2'b01;
    csrBus.wdata = 64'h1234;
    tick();
    trapPc       = 64'h3000;
    csrBus.idx   = 12'h340;
    csrBus.wdata = 64'h55;
    tick();
    trapValid    = 1'b0;
    csrBus.op    = 2'b00;
    readCsr(12'h341, v);
    checks++;
    if (v !== 64'h3000) begin failures++; $display("[TB] FAIL prio_mepc got=%h exp=%h", v, 64'h3000); end
    readCsr(12'h340, v);
    checks++;
    if (v !== 64'h55) begin failures++; $display("[TB] FAIL prio_mscratch got=%h exp=%h", v, 64'h55); end
    applyStimulus(12'h341, 2'b01, 64'h1237);
    readCsr(12'h341, v);
    checks++;
    if (v !== 64'h1234) begin failures++; $display("[TB] FAIL mepc_align got=%h exp=%h", v, 64'h1234); end
    applyStimulus(12'h300, 2'b01, 64'h80);
    mretValid    = 1'b1;
    csrBus.idx   = 12'h300;
    csrBus.op    = 2'b01;
    csrBus.wdata = 64'h0;
    tick();
    mretValid    = 1'b0;
    csrBus.op    = 2'b00;
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1888) begin failures++; $display("[TB] FAIL prio_mret_over_write got=%h exp=%h", v, 64'h1888); end
  endtask

  task automatic test_irq_illegal();
    logic [XLEN-1:0] v;
    applyStimulus(12'h300, 2'b01, 64'h8);
    applyStimulus(12'h304, 2'b01, 64'h80);
    irqTimer = 1'b1;
    #1;
    checks++;
    if (irqPending !== 1'b1) begin failures++; $display("[TB] FAIL irq_pending_on got=%b exp=1", irqPending); end
    readCsr(12'h344, v);
    checks++;
    if (v !== 64'h80) begin failures++; $display("[TB] FAIL mip_read got=%h exp=%h", v, 64'h80); end
    csrBus.idx = 12'h344;
    csrBus.op  = 2'b01;
    #1;
    checks++;
    if (csrBus.illegal !== 1'b0) begin failures++; $display("[TB] FAIL mip_write_legal got=%b exp=0", csrBus.illegal); end
    tick();
    csrBus.op = 2'b00;
    applyStimulus(12'h300, 2'b11, 64'h8);
    #1;
    checks++;
    if (irqPending !== 1'b0) begin failures++; $display("[TB] FAIL irq_pending_off got=%b exp=0", irqPending); end
    irqTimer     = 1'b0;
    csrBus.idx   = 12'h7C0;
    csrBus.op    = 2'b01;
    csrBus.wdata = 64'hFFFF;
    #1;
    checks++;
    if (csrBus.illegal !== 1'b1) begin failures++; $display("[TB] FAIL illegal_flag got=%b exp=1", csrBus.illegal); end
    checks++;
    if (csrBus.rdata !== 64'h0) begin failures++; $display("[TB] FAIL illegal_rdata got=%h exp=%h", csrBus.rdata, 64'h0); end
    csrBus.op = 2'b00;
    #1;
    checks++;
    if (csrBus.illegal !== 1'b0) begin failures++; $display("[TB] FAIL illegal_idle got=%b exp=0", csrBus.illegal); end
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    logic [XLEN-1:0] v;
    applyStimulus(12'hB00, 2'b01, '1);
    readCsr(12'hB00, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("[TB] FAIL mcycle_written got=%h exp=all-ones", v); end
    tick();
    readCsr(12'hB00, v);
    checks++;
    if (v !== 64'h0) begin failures++; $display("[TB] FAIL mcycle_wrap got=%h exp=%h", v, 64'h0); end
    tick();
    readCsr(12'hB00, v);
    checks++;
    if (v !== 64'h1) begin failures++; $display("[TB] FAIL mcycle_inc got=%h exp=%h", v, 64'h1); end
    applyStimulus(12'hB02, 2'b01, 64'h0);
    for (int i = 0; i < 3; i++) begin
      instret = 1'b1;
      tick();
      instret = 1'b0;
      tick();
    end
    readCsr(12'hB02, v);
    checks++;
    if (v !== 64'd3) begin failures++; $display("[TB] FAIL minstret_count got=%h exp=%h", v, 64'd3); end
    instret = 1'b1;
    applyStimulus(12'hB02, 2'b01, 64'd5);
    instret = 1'b0;
    readCsr(12'hB02, v);
    checks++;
    if (v !== 64'd5) begin failures++; $display("[TB] FAIL minstret_write_wins got=%h exp=%h", v, 64'd5); end
  endtask
`else
  task automatic test_counters();
    csrBus.idx = 12'hB00;
    csrBus.op  = 2'b10;
    #1;
    checks++;
    if (csrBus.illegal !== 1'b1) begin failures++; $display("[TB] FAIL mcycle_absent got=%b exp=1", csrBus.illegal); end
    csrBus.op = 2'b00;
  endtask
`endif

  task automatic test_reset_override();
    logic [XLEN-1:0] v;
    rst_n        = 1'b0;
    trapValid    = 1'b1;
    trapPc       = 64'h4444;
    csrBus.idx   = 12'h340;
    csrBus.op    = 2'b01;
    csrBus.wdata = 64'hABCD;
    tick();
    rst_n = 1'b1;
    idleInputs();
    readCsr(12'h340, v);
    checks++;
    if (v !== 64'h0) begin failures++; $display("[TB] FAIL rst_override_mscratch got=%h exp=%h", v, 64'h0); end
    checks++;
    if (mepcOut !== 64'h0) begin failures++; $display("[TB] FAIL rst_override_mepc got=%h exp=%h", mepcOut, 64'h0); end
    readCsr(12'h300, v);
    checks++;
    if (v !== 64'h1800) begin failures++; $display("[TB] FAIL rst_override_mstatus got=%h exp=%h", v, 64'h1800); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    trapCause = '0;
    trapPc    = '0;
    irqTimer  = 1'b0;
    idleInputs();
    test_reset();
    test_mtvec_warl();
    test_trap_mret();
    test_vectored();
    test_priority();
    test_irq_illegal();
    test_counters();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR file for the npc core, parametrised in XLEN. It holds the M-mode trap CSRs (mstatus, mie, mip, mtvec, mscratch, mepc, mcause) and optional performance counters. It supports csrrw/csrrs/csrrc read-modify-write, trap entry, mret and a timer-interrupt pending flag. It sits beside the register file in the execute/write-back stage and drives the trap redirect target to the PC-generation logic.

## Interface
Parameters:
- XLEN, 64, data width of every CSR and data port
- MTVEC_RST, 0, reset value of mtvec; bits [1:0] are masked to mode rules

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- csr_idx  in  12  CSR address
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_wdata  in  XLEN  rs1/uimm operand
- csr_rdata  out  XLEN  current (pre-update) value of the addressed CSR; combinational
- csr_illegal  out  1  high when csr_op!=00 and csr_idx is unimplemented
- trap_valid  in  1  trap taken this cycle
- trap_cause  in  XLEN  cause value; bit XLEN-1 = interrupt
- trap_pc  in  XLEN  PC of the trapping instruction
- mret_valid  in  1  mret retiring this cycle
- instret  in  1  one instruction retired this cycle
- irq_timer  in  1  level machine-timer interrupt request
- trap_target  out  XLEN  redirect PC for trap_valid
- mepc_out  out  XLEN  mret return PC
- irq_pending  out  1  mstatus.MIE & mie.MTIE & irq_timer

## Operation
- Implemented CSRs:
  - mstatus 0x300: stores MIE[3] and MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0.
  - mie 0x304: MTIE[7] only.
  - mip 0x344: read-only; MTIP[7]=irq_timer; writes are ignored and not flagged illegal.
  - mtvec 0x305: base[XLEN-1:2], mode[1:0]; WARL, mode bit1 forced 0 (modes 2/3 store as 0/1).
  - mscratch 0x340: full width.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: full width.
- Write value: write = d; set = old | d; clear = old & ~d. Any op != 00 to an implemented CSR counts as a write, including set/clear with d=0.
- Unimplemented index: csr_rdata=0, csr_illegal=1, no state change.
- Trap entry (trap_valid):
  - mepc <= trap_pc & ~3; mcause <= trap_cause; MPIE <= MIE; MIE <= 0.
- mret (mret_valid, no trap): MIE <= MPIE; MPIE <= 1.
- Priority in one cycle: trap > mret > CSR write. A lower-priority update to a CSR touched by a higher-priority event is dropped; writes to untouched CSRs still occur.
- trap_target:
  - mode 0: {base,2'b00}.
  - mode 1 with trap_cause[XLEN-1]=1: {base,2'b00} + (trap_cause[XLEN-2:0] << 2), truncated to XLEN.
  - mode 1 with an exception: {base,2'b00}.
- mepc_out = mepc.

## Timing
- All CSR state updates on the clk rising edge after the request cycle; csr_rdata, csr_illegal, trap_target, mepc_out and irq_pending are combinational from current state and inputs.
- A CSR write is visible on csr_rdata the next cycle; a same-cycle read returns the old value.
- Reset: every CSR is 0 except mtvec=MTVEC_RST (masked). Hence mepc_out=0, irq_pending=0, trap_target=MTVEC_RST-derived, and csr_rdata is 0 for all but mtvec/mstatus (mstatus reads 0x1800).
- Reset asserted mid-operation overrides trap, mret, writes and counter increments in that cycle.

## Configuration
- CSR_COUNTERS_EN defined: mcycle 0xB00 increments every cycle; minstret 0xB02 increments when instret=1. Both wrap from all-ones to 0. A CSR write in the same cycle wins over the increment. Both reset to 0.
- Undefined: 0xB00/0xB02 are unimplemented (read 0, csr_illegal=1) and no counter logic is built.

## Test plan
- Write mtvec=0x8000_0101 then read -> 0x8000_0101; write 0x8000_0103 -> reads 0x8000_0101; op 11 d=1 -> 0x8000_0100.
- mstatus MIE=1, trap_valid with trap_pc=0x8000_0010, cause=11 -> next cycle mepc=0x8000_0010, mcause=11, mstatus reads 0x1880; then mret -> reads 0x1888.
- mtvec=0x100|1, cause=0x8000_0000_0000_0007 -> trap_target=0x11C; cause=2 -> 0x100.
- Same cycle: trap_valid and csrrw mepc=0x1234 -> mepc=trap_pc; csrrw mscratch=0x55 in the same cycle still lands.
- MIE=1, MTIE=1, irq_timer=1 -> irq_pending=1, mip reads 0x80; clear MIE -> 0; csr_idx=0x7C0 op 01 -> csr_illegal=1, rdata 0.
- CSR_COUNTERS_EN: write mcycle=all-ones -> next cycle reads 0, then increments by 1 per cycle; 3 instret pulses -> minstret=3.
